// File: rtl/lookahead_ram_pkg.sv
// lookahead_ram_pkg: shared state type and helpers for the lookahead multiport RAM.
package lookahead_ram_pkg;
    localparam int MAX_DW = 1024;
    typedef enum logic {CLEAR, READY} state_t;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
    // Symbol s of new_w replaces symbol s of old_w wherever mask[s] is set.
    function automatic logic [MAX_DW-1:0] sym_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_DW-1:0] mask,
                                                   input int sw);
        logic [MAX_DW-1:0] r;
        for (int b = 0; b < MAX_DW; b++) r[b] = mask[10'(b / sw)] ? new_w[b] : old_w[b];
        return r;
    endfunction
endpackage

// File: rtl/lookahead_multiport_ram_if.sv
// lookahead_multiport_ram_if: write port plus NUM_RD packed read ports.
interface lookahead_multiport_ram_if import lookahead_ram_pkg::*; #(
    parameter int DATA_WIDTH   = 32,
    parameter int SYMBOL_WIDTH = 8,
    parameter int DEPTH        = 16,
    parameter int NUM_RD       = 2
);
    localparam int AW   = clog2_min1(DEPTH);
    localparam int NSYM = DATA_WIDTH / SYMBOL_WIDTH;
    logic [AW-1:0]                wr_address;
    logic [DATA_WIDTH-1:0]        wr_writedata;
    logic [NSYM-1:0]              wr_byteenable;
    logic                         wr_write;
    logic                         wr_waitrequest;
    logic [NUM_RD*AW-1:0]         rd_address;
    logic [NUM_RD-1:0]            rd_read;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_readdata;
    logic [NUM_RD-1:0]            rd_readdatavalid;
    modport master (
        output wr_address, wr_writedata, wr_byteenable, wr_write, rd_address, rd_read,
        input  wr_waitrequest, rd_readdata, rd_readdatavalid
    );
    modport slave (
        input  wr_address, wr_writedata, wr_byteenable, wr_write, rd_address, rd_read,
        output wr_waitrequest, rd_readdata, rd_readdatavalid
    );
endinterface

// File: rtl/lookahead_rd_port.sv
// lookahead_rd_port: one array replica with a two-stage read pipeline that folds in writes from the read cycle and the next.
module lookahead_rd_port import lookahead_ram_pkg::*; #(
    parameter int DATA_WIDTH   = 32,
    parameter int SYMBOL_WIDTH = 8,
    parameter int DEPTH        = 16,
    parameter int AW           = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               we,
    input  logic [AW-1:0]                      waddr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [DATA_WIDTH/SYMBOL_WIDTH-1:0] wbe,
    input  logic                               re,
    input  logic [AW-1:0]                      raddr,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic                               rvalid
);
    localparam int NSYM = DATA_WIDTH / SYMBOL_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q1, b1;
    logic [NSYM-1:0]       m1, m2;
    logic [AW-1:0]         a1;
    logic                  v1, oor1;
    assign m2 = {NSYM{we && waddr == a1}} & wbe;
    // Storage has no reset so it maps onto block RAM; the read sees pre-write contents.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSYM; s++)
            if (we && wbe[s]) mem[waddr][s*SYMBOL_WIDTH +: SYMBOL_WIDTH] <= wdata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        q1 <= mem[raddr];
        a1 <= raddr;
        oor1 <= int'(raddr) >= DEPTH;
        b1 <= wdata;
        m1 <= {NSYM{we && waddr == raddr}} & wbe;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            rvalid <= 1'b0;
            rdata <= '0;
        end else begin
            v1 <= re;
            rvalid <= v1;
            if (v1) rdata <= oor1 ? '0 : DATA_WIDTH'(sym_merge(
                sym_merge(MAX_DW'(q1), MAX_DW'(b1), MAX_DW'(m1), SYMBOL_WIDTH),
                MAX_DW'(wdata), MAX_DW'(m2), SYMBOL_WIDTH));
        end
    end
endmodule

// File: rtl/lookahead_multiport_ram.sv
// lookahead_multiport_ram: one write port, NUM_RD bypassing read ports, optional zeroing sweep after reset.
module lookahead_multiport_ram import lookahead_ram_pkg::*; #(
    parameter int DATA_WIDTH     = 32,
    parameter int SYMBOL_WIDTH   = 8,
    parameter int DEPTH          = 16,
    parameter int NUM_RD         = 2,
    parameter bit CLEAR_ON_RESET = 1
) (
    input logic clk,
    input logic reset_n,
    lookahead_multiport_ram_if.slave bus
);
    localparam int AW   = clog2_min1(DEPTH);
    localparam int NSYM = DATA_WIDTH / SYMBOL_WIDTH;
    state_t                state;
    logic [AW-1:0]         clr_addr, waddr;
    logic                  sweep, we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NSYM-1:0]       wbe;
    logic [DATA_WIDTH-1:0] rdata [NUM_RD];
    logic [NUM_RD-1:0]     rvalid;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= CLEAR;
            clr_addr <= AW'(DEPTH - 1);
            bus.wr_waitrequest <= 1'b1;
        end else begin
            bus.wr_waitrequest <= CLEAR_ON_RESET && state != READY;
            if (state == CLEAR) begin
                if (!CLEAR_ON_RESET || clr_addr == '0) state <= READY;
                else clr_addr <= clr_addr - 1'b1;
            end
        end
    end
    // The sweep owns the write port until READY; waitrequest keeps users off it.
    always_comb begin
        sweep = reset_n && CLEAR_ON_RESET && state == CLEAR;
        we = sweep || (reset_n && !bus.wr_waitrequest && bus.wr_write && int'(bus.wr_address) < DEPTH);
        waddr = sweep ? clr_addr : bus.wr_address;
        wdata = sweep ? '0 : bus.wr_writedata;
        wbe = sweep ? '1 : bus.wr_byteenable;
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        lookahead_rd_port #(
            .DATA_WIDTH(DATA_WIDTH), .SYMBOL_WIDTH(SYMBOL_WIDTH), .DEPTH(DEPTH), .AW(AW)
        ) u_rd (
            .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
            .re(reset_n && !bus.wr_waitrequest && bus.rd_read[i]),
            .raddr(bus.rd_address[i*AW +: AW]),
            .rdata(rdata[i]), .rvalid(rvalid[i])
        );
        assign bus.rd_readdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata[i];
    end
    assign bus.rd_readdatavalid = rvalid;
endmodule

// File: tb/tb_lookahead_multiport_ram.sv
// tb_lookahead_multiport_ram: directed checks of the clearing sweep, lookahead bypass, port independence and out-of-range access.
module tb_lookahead_multiport_ram;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] model [16];
    logic [3:0] ra0 [100];
    logic [3:0] ra1 [100];
    lookahead_multiport_ram_if #(.DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(16), .NUM_RD(2)) ifa ();
    lookahead_multiport_ram_if #(.DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(12), .NUM_RD(2)) ifb ();
    lookahead_multiport_ram #(.DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(16), .NUM_RD(2), .CLEAR_ON_RESET(1))
        dut_a (.clk(clk), .reset_n(rst_a), .bus(ifa));
    lookahead_multiport_ram #(.DATA_WIDTH(32), .SYMBOL_WIDTH(8), .DEPTH(12), .NUM_RD(2), .CLEAR_ON_RESET(0))
        dut_b (.clk(clk), .reset_n(rst_b), .bus(ifb));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        ifa.wr_write = 1'b1; ifa.wr_address = a; ifa.wr_writedata = d; ifa.wr_byteenable = be;
        step();
        ifa.wr_write = 1'b0;
    endtask

    task automatic rd2(input logic [3:0] a0, input logic [3:0] a1, input logic [31:0] e0, input logic [31:0] e1, input string tag);
        ifa.rd_read = 2'b11; ifa.rd_address = {a1, a0};
        step();
        ifa.rd_read = 2'b00;
        chk({tag, "_valid_early"}, 32'(ifa.rd_readdatavalid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(ifa.rd_readdatavalid), 32'd3);
        chk({tag, "_data0"}, ifa.rd_readdata[31:0], e0);
        chk({tag, "_data1"}, ifa.rd_readdata[63:32], e1);
    endtask

    task automatic wait_ready_a(output int n, output logic saw_v);
        n = 0; saw_v = 1'b0;
        while (ifa.wr_waitrequest && n < 60) begin
            step();
            n++;
            saw_v |= |ifa.rd_readdatavalid;
        end
    endtask

    initial begin
        int n;
        logic saw_v;
        logic [3:0] wa, wbe;
        logic [31:0] wd;
        logic ww;
        ifa.wr_address = '0; ifa.wr_writedata = '0; ifa.wr_byteenable = '0; ifa.wr_write = 1'b0;
        ifa.rd_address = '0; ifa.rd_read = '0;
        ifb.wr_address = '0; ifb.wr_writedata = '0; ifb.wr_byteenable = '0; ifb.wr_write = 1'b0;
        ifb.rd_address = '0; ifb.rd_read = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset values and the clearing sweep
        repeat (3) step();
        chk("rst_waitrequest", 32'(ifa.wr_waitrequest), 32'd1);
        chk("rst_valid", 32'(ifa.rd_readdatavalid), 32'd0);
        chk("rst_readdata", ifa.rd_readdata[31:0], 32'd0);
        chk("rst_b_waitrequest", 32'(ifb.wr_waitrequest), 32'd1);
        rst_a = 1'b1;
        wait_ready_a(n, saw_v);
        chk("sweep_edges", 32'(n), 32'd17);
        chk("sweep_no_valid", 32'(saw_v), 32'd0);
        for (int a = 0; a < 16; a++) rd2(4'(a), 4'(15 - a), 32'd0, 32'd0, "clear_read");

        // Same-cycle and next-cycle bypass
        wr_a(4'd5, 32'h11223344, 4'b1111);
        ifa.rd_read = 2'b01; ifa.rd_address = {4'd0, 4'd5};
        ifa.wr_write = 1'b1; ifa.wr_address = 4'd5; ifa.wr_writedata = 32'hAABBCCDD; ifa.wr_byteenable = 4'b0011;
        step();
        ifa.rd_read = 2'b00;
        ifa.wr_writedata = 32'h55667788; ifa.wr_byteenable = 4'b0100;
        step();
        ifa.wr_write = 1'b0;
        chk("bypass_valid", 32'(ifa.rd_readdatavalid), 32'd1);
        chk("bypass_data", ifa.rd_readdata[31:0], 32'h1166CCDD);
        rd2(4'd5, 4'd5, 32'h1166CCDD, 32'h1166CCDD, "bypass_stored");

        // Bypass horizon: a write two cycles after the read is not seen
        wr_a(4'd7, 32'hCAFEF00D, 4'b1111);
        ifa.rd_read = 2'b01; ifa.rd_address = {4'd0, 4'd7};
        step();
        ifa.rd_read = 2'b10; ifa.rd_address = {4'd7, 4'd0};
        step();
        ifa.rd_read = 2'b00;
        chk("horizon_valid_a", 32'(ifa.rd_readdatavalid), 32'd1);
        chk("horizon_old", ifa.rd_readdata[31:0], 32'hCAFEF00D);
        wr_a(4'd7, 32'h12345678, 4'b1111);
        chk("horizon_valid_a1", 32'(ifa.rd_readdatavalid), 32'd2);
        chk("horizon_new", ifa.rd_readdata[63:32], 32'h12345678);
        chk("horizon_hold", ifa.rd_readdata[31:0], 32'hCAFEF00D);
        model[5] = 32'h1166CCDD;
        model[7] = 32'h12345678;

        // Random back-to-back reads on both ports with random writes; the read
        // issued in cycle c must equal the memory once cycle c+1's write lands.
        for (int c = 0; c <= 100; c++) begin
            if (c < 100) begin
                ra0[c] = 4'($urandom_range(15));
                ra1[c] = 4'($urandom_range(15));
                ifa.rd_read = 2'b11; ifa.rd_address = {ra1[c], ra0[c]};
            end else ifa.rd_read = 2'b00;
            ww = 1'($urandom_range(1)); wa = 4'($urandom_range(15)); wd = $urandom(); wbe = 4'($urandom_range(15));
            ifa.wr_write = ww; ifa.wr_address = wa; ifa.wr_writedata = wd; ifa.wr_byteenable = wbe;
            step();
            if (ww) for (int s = 0; s < 4; s++) if (wbe[s]) model[wa][s*8 +: 8] = wd[s*8 +: 8];
            if (c >= 1) begin
                chk("rand_valid", 32'(ifa.rd_readdatavalid), 32'd3);
                chk("rand_data0", ifa.rd_readdata[31:0], model[ra0[c-1]]);
                chk("rand_data1", ifa.rd_readdata[63:32], model[ra1[c-1]]);
            end
        end
        ifa.wr_write = 1'b0;
        step();
        chk("rand_valid_drop", 32'(ifa.rd_readdatavalid), 32'd0);

        // Reset in the middle of a sweep, with reads held asserted throughout
        rst_a = 1'b0;
        step(); step();
        chk("rst2_waitrequest", 32'(ifa.wr_waitrequest), 32'd1);
        chk("rst2_readdata", ifa.rd_readdata[31:0], 32'd0);
        rst_a = 1'b1;
        ifa.rd_read = 2'b11; ifa.rd_address = {4'd3, 4'd9};
        saw_v = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            saw_v |= |ifa.rd_readdatavalid;
        end
        chk("midsweep_no_valid", 32'(saw_v), 32'd0);
        rst_a = 1'b0;
        step();
        chk("midsweep_rst_wait", 32'(ifa.wr_waitrequest), 32'd1);
        rst_a = 1'b1;
        wait_ready_a(n, saw_v);
        ifa.rd_read = 2'b00;
        chk("resweep_edges", 32'(n), 32'd17);
        chk("resweep_no_valid", 32'(saw_v), 32'd0);
        for (int a = 0; a < 16; a++) rd2(4'(a), 4'(15 - a), 32'd0, 32'd0, "reclear_read");

        // Out-of-range access and no clear sweep on the DEPTH=12 instance
        rst_b = 1'b1;
        n = 0;
        while (ifb.wr_waitrequest && n < 20) begin
            step();
            n++;
        end
        chk("noclear_edges", 32'(n), 32'd1);
        ifb.wr_write = 1'b1; ifb.wr_address = 4'd3; ifb.wr_writedata = 32'h0BADF00D; ifb.wr_byteenable = 4'b1111;
        step();
        ifb.wr_address = 4'd13; ifb.wr_writedata = 32'hDEADBEEF;
        ifb.rd_read = 2'b11; ifb.rd_address = {4'd3, 4'd13};
        step();
        ifb.wr_write = 1'b0; ifb.rd_read = 2'b00;
        step();
        chk("oor_valid", 32'(ifb.rd_readdatavalid), 32'd3);
        chk("oor_data", ifb.rd_readdata[31:0], 32'd0);
        chk("inrange_data", ifb.rd_readdata[63:32], 32'h0BADF00D);
        ifb.rd_read = 2'b01; ifb.rd_address = {4'd0, 4'd13};
        step();
        ifb.rd_read = 2'b00;
        step();
        chk("oor_reread", ifb.rd_readdata[31:0], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
